implication_monitor: RTL

- Synthesizable multi-channel checker for the windowed implication `ant |-> ##[MIN_DELAY:MAX_DELAY] cons`.
- Generalises the overlapping case (0:0) and the non-overlapping case (1:1) to any bounded window and to N independent channels.
- Tracks every open obligation in a per-channel age scoreboard and reports pass, fail, sticky errors and counts.
- Sits beside the logic under check, in simulation or on silicon, as a runtime monitor for properties the formal flow also proves.

---
 rtl/implication_monitor.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/implication_monitor.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// implication_monitor
//
// Multi-channel runtime checker for  ant |-> ##[MIN_DELAY:MAX_DELAY] cons.
// Every channel keeps a one-hot-per-age scoreboard of open obligations
// (ages 1..MAX_DELAY); age 0 is the live antecedent of the current cycle.
// A consequent discharges every open obligation whose age lies inside the
// window; an obligation that reaches MAX_DELAY undischarged fails.
//
// Optional feature macro: IMPLICATION_MONITOR_SVA_EN
//   When defined, per-channel concurrent assertions/covers of the property
//   are compiled next to the scoreboard so formal can cross-check the two.
// ---------------------------------------------------------------------------
module implication_monitor #(
   parameter int CHANNELS  = 1,
   parameter int MIN_DELAY = 0,
   parameter int MAX_DELAY = 1,
   parameter int CNT_W     = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                disable_i,
   input  logic [CHANNELS-1:0] ant_i,
   input  logic [CHANNELS-1:0] cons_i,
   output logic [CHANNELS-1:0] pass_o,
   output logic [CHANNELS-1:0] fail_o,
   output logic [CHANNELS-1:0] fail_sticky_o,
   output logic [CNT_W-1:0]    pass_cnt_o,
   output logic [CNT_W-1:0]    fail_cnt_o
);

   // ------------------------------------------------------------------
   // Parameter legality; any violation stops elaboration.
   // ------------------------------------------------------------------
   if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
      $error("implication_monitor: CHANNELS must be in 1..32");
   end
   if (MIN_DELAY < 0 || MIN_DELAY > MAX_DELAY) begin : g_bad_min
      $error("implication_monitor: MIN_DELAY must be in 0..MAX_DELAY");
   end
   if (MAX_DELAY > 31) begin : g_bad_max
      $error("implication_monitor: MAX_DELAY must not exceed 31");
   end
   if (CNT_W < 1) begin : g_bad_cnt
      $error("implication_monitor: CNT_W must be at least 1");
   end

   // Number of age slots per channel, including the live age-0 term.
   localparam int AGES = MAX_DELAY + 1;

   // Ages at or above MIN_DELAY may be discharged by a consequent.
   localparam logic [MAX_DELAY:0] WIN_MASK = {AGES{1'b1}} << MIN_DELAY;

   // Counter increments are computed in a wider sum so saturation can be
   // detected before truncation. At most 32*32 = 1024 discharges per cycle,
   // so 12 spare bits always cover the worst-case increment.
   localparam int SUM_W = CNT_W + 12;
   localparam logic [SUM_W-1:0] CNT_MAX = {{12{1'b0}}, {CNT_W{1'b1}}};

   // An asserted disable_i kills the whole cycle: no new obligation, no
   // discharge, no expiry.
   logic live;
   assign live = ~disable_i;

   // Flattened per-age discharge terms of all channels, for the pass counter.
   logic [CHANNELS*AGES-1:0] dis_all;
   logic [CHANNELS-1:0]      pass_t;
   logic [CHANNELS-1:0]      fail_t;

   // ------------------------------------------------------------------
   // Per-channel scoreboard
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic             a0;
      logic [MAX_DELAY:0] age;    // age[k] = obligation of age k is open
      logic [MAX_DELAY:0] dis_v;  // age[k] discharged this cycle

      assign a0 = ant_i[gi] & live;

      if (MAX_DELAY > 0) begin : g_pend
         // pend_reg[k-1] holds the obligation of age k (k = 1..MAX_DELAY).
         logic [MAX_DELAY-1:0] pend_reg;

         assign age = {pend_reg, a0};

         // Age every undischarged obligation by one; reset and disable drop all.
         always_ff @(posedge clk) begin
            if (rst || disable_i) begin
               pend_reg <= '0;
            end else begin
               pend_reg <= age[MAX_DELAY-1:0] & ~dis_v[MAX_DELAY-1:0];
            end
         end
      end else begin : g_no_pend
         // Overlapping case: the verdict is decided in the antecedent cycle.
         assign age = a0;
      end

      assign dis_v       = age & WIN_MASK & {AGES{cons_i[gi] & live}};
      assign fail_t[gi]  = age[MAX_DELAY] & ~dis_v[MAX_DELAY] & live;
      assign pass_t[gi]  = |dis_v;
      assign dis_all[gi*AGES +: AGES] = dis_v;
   end

   // ------------------------------------------------------------------
   // Population counts feeding the saturating counters
   // ------------------------------------------------------------------
   logic [SUM_W-1:0] pass_inc;
   logic [SUM_W-1:0] fail_inc;
   logic [SUM_W-1:0] pass_sum;
   logic [SUM_W-1:0] fail_sum;
   logic [CNT_W-1:0] pass_cnt_next;
   logic [CNT_W-1:0] fail_cnt_next;

   // Count every discharged obligation and every expired obligation.
   always_comb begin
      pass_inc = '0;
      fail_inc = '0;
      for (int i = 0; i < CHANNELS*AGES; i++) begin
         pass_inc = pass_inc + SUM_W'(dis_all[i]);
      end
      for (int i = 0; i < CHANNELS; i++) begin
         fail_inc = fail_inc + SUM_W'(fail_t[i]);
      end
   end

   // Saturating add: clamp to all-ones instead of wrapping.
   always_comb begin
      pass_sum = {12'b0, pass_cnt_o} + pass_inc;
      fail_sum = {12'b0, fail_cnt_o} + fail_inc;
      pass_cnt_next = (pass_sum > CNT_MAX) ? {CNT_W{1'b1}} : pass_sum[CNT_W-1:0];
      fail_cnt_next = (fail_sum > CNT_MAX) ? {CNT_W{1'b1}} : fail_sum[CNT_W-1:0];
   end

   // ------------------------------------------------------------------
   // Registered verdicts, sticky flags and counters
   // ------------------------------------------------------------------
   // Verdict pulses follow the evaluation cycle by one clock; a disabled
   // cycle has all terms forced low, so counters and sticky bits hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         pass_o        <= '0;
         fail_o        <= '0;
         fail_sticky_o <= '0;
         pass_cnt_o    <= '0;
         fail_cnt_o    <= '0;
      end else begin
         pass_o        <= pass_t;
         fail_o        <= fail_t;
         fail_sticky_o <= fail_sticky_o | fail_t;
         pass_cnt_o    <= pass_cnt_next;
         fail_cnt_o    <= fail_cnt_next;
      end
   end

`ifdef IMPLICATION_MONITOR_SVA_EN
   // ------------------------------------------------------------------
   // Concurrent properties mirroring the scoreboard, for formal cross-check.
   // ------------------------------------------------------------------
   default clocking cb_mon @(posedge clk); endclocking
   default disable iff (rst || disable_i);

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_sva
      // The property itself, as the tool's SVA engine evaluates it.
      a_impl: assert property (ant_i[gi] |-> ##[MIN_DELAY:MAX_DELAY] cons_i[gi]);
      c_impl: cover property (ant_i[gi] ##[MIN_DELAY:MAX_DELAY] cons_i[gi]);

      // cons_seen[k]: a consequent arrived k cycles after the antecedent
      // that would be expiring now (only window ages matter).
      logic [MAX_DELAY:0] cons_seen;
      for (genvar gk = 0; gk <= MAX_DELAY; gk++) begin : g_seen
         if (gk >= MIN_DELAY) begin : g_in
            assign cons_seen[gk] = $past(cons_i[gi], MAX_DELAY + 1 - gk);
         end else begin : g_out
            assign cons_seen[gk] = 1'b0;
         end
      end

      // A fail pulse must trace back to an antecedent whose window stayed empty.
      a_fail_src: assert property (
         fail_o[gi] |-> ($past(ant_i[gi], MAX_DELAY + 1) && !(|cons_seen)));
   end
`endif

endmodule
